// File: rtl/eq_mask_pkg.sv
// Shared constants and elaboration helpers for the masked multi-pattern comparator.
package eq_mask_pkg;

  localparam int LATENCY   = 3;
  localparam int CHUNK_W   = 6;
  localparam int GRP_FANIN = 6;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eq_mask_multi_pipe_eq_6_mask_r.sv
// Registered masked 6-bit equality: one LUT6-sized slice of the stage-1 compare.
module eq_6_mask_r
  import eq_mask_pkg::*;
(
  input  logic               clk,
  input  logic               arst_n,
  input  logic [CHUNK_W-1:0] din,
  input  logic [CHUNK_W-1:0] pat,
  input  logic [CHUNK_W-1:0] care,
  output logic               match_r
);

  logic match_q;
  logic match_d;

  assign match_d = ~|((din ^ pat) & care);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) match_q <= 1'b0;
    else         match_q <= match_d;
  end

  assign match_r = match_q;

endmodule

// File: rtl/eq_mask_multi_pipe.sv
// Runtime-programmable masked multi-pattern comparator, fixed 3-stage pipeline.
// Optional saturating hit counter enabled by defining EQ_MASK_HIT_CNT_EN.
module eq_mask_multi_pipe
  import eq_mask_pkg::*;
#(
  parameter int WIDTH   = 66,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [WIDTH-1:0]                 din,
  input  logic                             din_valid,
  input  logic                             wr_en,
  input  logic [clog2_min1(NUM_PAT)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]                 wr_pat,
  input  logic [WIDTH-1:0]                 wr_care,
  input  logic                             wr_ena,
  output logic                             match_valid,
  output logic [NUM_PAT-1:0]               match_vec,
  output logic                             match_any,
  output logic [clog2_min1(NUM_PAT)-1:0]   match_idx
`ifdef EQ_MASK_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0]                 hit_cnt,
  input  logic                             hit_cnt_clr
`endif
);

  localparam int CHUNKS = ceil_div(WIDTH, CHUNK_W);
  localparam int GROUPS = ceil_div(CHUNKS, GRP_FANIN);
  localparam int PAD_W  = CHUNKS * CHUNK_W;
  localparam int IDX_W  = clog2_min1(NUM_PAT);

  if (WIDTH < 1 || WIDTH > 216 || NUM_PAT < 1 || NUM_PAT > 16 || CNT_W < 1) begin : g_bad_param
    $error("eq_mask_multi_pipe: parameter out of range");
  end

  logic [NUM_PAT-1:0][WIDTH-1:0] pat_q;
  logic [NUM_PAT-1:0][WIDTH-1:0] care_q;
  logic [NUM_PAT-1:0]            ena_q;

  // Out-of-range addresses match no entry and are therefore dropped.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pat_q  <= '0;
      care_q <= '0;
      ena_q  <= '0;
    end else begin
      for (int e = 0; e < NUM_PAT; e++) begin
        if (wr_en && (wr_addr == IDX_W'(e))) begin
          pat_q[e]  <= wr_pat;
          care_q[e] <= wr_care;
          ena_q[e]  <= wr_ena;
        end
      end
    end
  end

  // Padding bits carry care=0 so the top chunk ignores them.
  logic [PAD_W-1:0]              din_pad;
  logic [NUM_PAT-1:0][PAD_W-1:0] pat_pad;
  logic [NUM_PAT-1:0][PAD_W-1:0] care_pad;

  assign din_pad = PAD_W'(din);

  // ---- stage 1: per-chunk masked equality ----
  logic [NUM_PAT-1:0][CHUNKS-1:0] chunk_p1;
  logic [NUM_PAT-1:0]             ena_p1;
  logic                           vld_p1;

  for (genvar e = 0; e < NUM_PAT; e++) begin : g_ent
    assign pat_pad[e]  = PAD_W'(pat_q[e]);
    assign care_pad[e] = PAD_W'(care_q[e]);
    for (genvar c = 0; c < CHUNKS; c++) begin : g_chk
      eq_6_mask_r u_eq (
        .clk     (clk),
        .arst_n  (arst_n),
        .din     (din_pad[c*CHUNK_W +: CHUNK_W]),
        .pat     (pat_pad[e][c*CHUNK_W +: CHUNK_W]),
        .care    (care_pad[e][c*CHUNK_W +: CHUNK_W]),
        .match_r (chunk_p1[e][c])
      );
    end
  end

  // ena travels with the word so later writes never touch in-flight data.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_p1 <= 1'b0;
      ena_p1 <= '0;
    end else begin
      vld_p1 <= din_valid;
      ena_p1 <= ena_q;
    end
  end

  // ---- stage 2: AND chunks within each group ----
  logic [NUM_PAT-1:0][GROUPS-1:0] grp_d;
  logic [NUM_PAT-1:0][GROUPS-1:0] grp_p2;
  logic [NUM_PAT-1:0]             ena_p2;
  logic                           vld_p2;

  always_comb begin
    grp_d = '1;
    for (int e = 0; e < NUM_PAT; e++) begin
      for (int c = 0; c < CHUNKS; c++) begin
        grp_d[e][c / GRP_FANIN] = grp_d[e][c / GRP_FANIN] & chunk_p1[e][c];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      grp_p2 <= '0;
      ena_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      grp_p2 <= grp_d;
      ena_p2 <= ena_p1;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 3: final AND, priority index, output register ----
  logic [NUM_PAT-1:0] hit_d;
  logic               any_d;
  logic [IDX_W-1:0]   idx_d;

  always_comb begin
    hit_d = '0;
    idx_d = '0;
    for (int e = 0; e < NUM_PAT; e++) begin
      hit_d[e] = vld_p2 & ena_p2[e] & (&grp_p2[e]);
    end
    for (int e = NUM_PAT - 1; e >= 0; e--) begin
      if (hit_d[e]) idx_d = IDX_W'(e);
    end
  end

  assign any_d = |hit_d;

  logic               match_valid_q;
  logic [NUM_PAT-1:0] match_vec_q;
  logic               match_any_q;
  logic [IDX_W-1:0]   match_idx_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      match_valid_q <= 1'b0;
      match_vec_q   <= '0;
      match_any_q   <= 1'b0;
      match_idx_q   <= '0;
    end else begin
      match_valid_q <= vld_p2;
      match_vec_q   <= hit_d;
      match_any_q   <= any_d;
      match_idx_q   <= idx_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_vec   = match_vec_q;
  assign match_any   = match_any_q;
  assign match_idx   = match_idx_q;

`ifdef EQ_MASK_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] hit_cnt_d;

  // Clear has priority; the count sticks at all-ones instead of wrapping.
  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if (hit_cnt_clr)                                       hit_cnt_d = '0;
    else if (match_valid_q && match_any_q && !(&hit_cnt_q)) hit_cnt_d = hit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) hit_cnt_q <= '0;
    else         hit_cnt_q <= hit_cnt_d;
  end

  assign hit_cnt = hit_cnt_q;
`endif

endmodule

// File: tb/tb_eq_mask_multi_pipe.sv
// Self-checking bench: behavioural table model plus directed literal checks.
module tb_eq_mask_multi_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n;
  logic [65:0] din;
  logic        din_valid;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [65:0] wr_pat;
  logic [65:0] wr_care;
  logic        wr_ena;
  logic        match_valid;
  logic [3:0]  match_vec;
  logic        match_any;
  logic [1:0]  match_idx;

  logic [12:0] s_din;
  logic        s_valid;
  logic        s_wr_en;
  logic [0:0]  s_wr_addr;
  logic [12:0] s_wr_pat;
  logic [12:0] s_wr_care;
  logic        s_wr_ena;
  logic        s_mv;
  logic [0:0]  s_vec;
  logic        s_any;
  logic [0:0]  s_idx;

`ifdef EQ_MASK_HIT_CNT_EN
  logic [3:0]  hit_cnt;
  logic        hit_cnt_clr;
  logic [31:0] s_hit_cnt;
  logic        s_hit_cnt_clr;
`endif

  eq_mask_multi_pipe #(.WIDTH(66), .NUM_PAT(4), .CNT_W(4)) dut (
    .clk(clk), .arst_n(arst_n), .din(din), .din_valid(din_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_pat(wr_pat), .wr_care(wr_care), .wr_ena(wr_ena),
    .match_valid(match_valid), .match_vec(match_vec), .match_any(match_any), .match_idx(match_idx)
`ifdef EQ_MASK_HIT_CNT_EN
    , .hit_cnt(hit_cnt), .hit_cnt_clr(hit_cnt_clr)
`endif
  );

  eq_mask_multi_pipe #(.WIDTH(13), .NUM_PAT(1)) dut_s (
    .clk(clk), .arst_n(arst_n), .din(s_din), .din_valid(s_valid),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_pat(s_wr_pat), .wr_care(s_wr_care), .wr_ena(s_wr_ena),
    .match_valid(s_mv), .match_vec(s_vec), .match_any(s_any), .match_idx(s_idx)
`ifdef EQ_MASK_HIT_CNT_EN
    , .hit_cnt(s_hit_cnt), .hit_cnt_clr(s_hit_cnt_clr)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: table of entries, per-edge history of expected results.
  logic [65:0] m_pat [4];
  logic [65:0] m_care[4];
  logic [3:0]  m_ena;
  bit          hist_v  [4096];
  logic [3:0]  hist_vec[4096];
  int          cyc = 0;
  int          flushed_upto = 0;
`ifdef EQ_MASK_HIT_CNT_EN
  int          m_cnt = 0;
`endif

  function automatic void expect_at(input int m, output bit v, output logic [3:0] vec);
    int s;
    s   = m - eq_mask_pkg::LATENCY + 1;
    v   = 1'b0;
    vec = '0;
    if (arst_n === 1'b1 && s >= 1 && s > flushed_upto && s < 4096) begin
      v   = hist_v[s];
      vec = hist_vec[s];
    end
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] vec);
    logic [1:0] r;
    r = '0;
    for (int e = 3; e >= 0; e--) if (vec[e]) r = 2'(e);
    return r;
  endfunction

  always @(negedge arst_n) begin
    for (int e = 0; e < 4; e++) begin
      m_pat[e]  = '0;
      m_care[e] = '0;
    end
    m_ena        = '0;
    flushed_upto = cyc;
`ifdef EQ_MASK_HIT_CNT_EN
    m_cnt = 0;
`endif
  end

  always @(posedge clk) begin
    bit         v;
    logic [3:0] vec;
`ifdef EQ_MASK_HIT_CNT_EN
    expect_at(cyc, v, vec);
    if (arst_n !== 1'b1)          m_cnt = 0;
    else if (hit_cnt_clr)         m_cnt = 0;
    else if (v && vec != 0 && m_cnt < 15) m_cnt = m_cnt + 1;
`endif
    cyc++;
    if (arst_n !== 1'b1) begin
      flushed_upto = cyc;
    end else if (cyc < 4096) begin
      vec = '0;
      for (int e = 0; e < 4; e++)
        if (m_ena[e] && (((din ^ m_pat[e]) & m_care[e]) == 66'd0)) vec[e] = 1'b1;
      hist_v[cyc]   = din_valid;
      hist_vec[cyc] = din_valid ? vec : 4'b0;
      if (wr_en) begin
        m_pat[wr_addr]  = wr_pat;
        m_care[wr_addr] = wr_care;
        m_ena[wr_addr]  = wr_ena;
      end
    end
  end

  always @(negedge clk) begin
    bit         v;
    logic [3:0] vec;
    expect_at(cyc, v, vec);
    chk("valid", 66'(match_valid), 66'(v));
    chk("vec",   66'(match_vec),   66'(vec));
    chk("any",   66'(match_any),   66'(|vec));
    chk("idx",   66'(match_idx),   66'(lowest(vec)));
`ifdef EQ_MASK_HIT_CNT_EN
    chk("hit_cnt", 66'(hit_cnt), 66'(m_cnt));
`endif
  end

  // Post-reset window counters for the mid-stream reset scenario.
  bit count_en = 0;
  int post_valid = 0;
  int post_any = 0;
  always @(negedge clk) begin
    if (count_en) begin
      if (match_valid === 1'b1) post_valid++;
      if (match_any === 1'b1)   post_any++;
    end
  end

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic write(input logic [1:0] a, input logic [65:0] p, input logic [65:0] c, input logic en);
    go();
    wr_addr = a; wr_pat = p; wr_care = c; wr_ena = en; wr_en = 1'b1;
    go();
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [65:0] d);
    go();
    din = d; din_valid = 1'b1;
    go();
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [3:0] vec, input logic [1:0] idx);
    chk({nm, ".valid"}, 66'(match_valid), 66'd1);
    chk({nm, ".vec"},   66'(match_vec),   66'(vec));
    chk({nm, ".any"},   66'(match_any),   66'(|vec));
    chk({nm, ".idx"},   66'(match_idx),   66'(idx));
  endtask

  task automatic s_write(input logic [0:0] a, input logic [12:0] p, input logic [12:0] c, input logic en);
    go();
    s_wr_addr = a; s_wr_pat = p; s_wr_care = c; s_wr_ena = en; s_wr_en = 1'b1;
    go();
    s_wr_en = 1'b0;
  endtask

  task automatic s_send(input string nm, input logic [12:0] d, input logic hit);
    go();
    s_din = d; s_valid = 1'b1;
    go();
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({nm, ".valid"}, 66'(s_mv),  66'd1);
    chk({nm, ".vec"},   66'(s_vec), 66'(hit));
    chk({nm, ".any"},   66'(s_any), 66'(hit));
    chk({nm, ".idx"},   66'(s_idx), 66'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    din = '0; din_valid = 0; wr_en = 0; wr_addr = '0; wr_pat = '0; wr_care = '0; wr_ena = 0;
    s_din = '0; s_valid = 0; s_wr_en = 0; s_wr_addr = '0; s_wr_pat = '0; s_wr_care = '0; s_wr_ena = 0;
`ifdef EQ_MASK_HIT_CNT_EN
    hit_cnt_clr = 0; s_hit_cnt_clr = 0;
`endif
    arst_n = 1'b1;
    #1 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 arst_n = 1'b1;

    // Cleared table: valid word, no hits.
    send(66'h2_AAAA_AAAA_AAAA_AAAA);
    lit("t1", 4'b0000, 2'd0);

    // Exact full-width pattern on entry 2.
    write(2'd2, 66'h1234, {66{1'b1}}, 1'b1);
    send(66'h1234);  lit("t2hit", 4'b0100, 2'd2);
    send(66'h1235);  lit("t2miss", 4'b0000, 2'd0);

    // Partial care on entry 0, match-all on entry 3.
    write(2'd0, 66'h1, 66'h3, 1'b1);
    write(2'd3, 66'h0, 66'h0, 1'b1);
    send(66'h5);     lit("t3a", 4'b1001, 2'd0);
    send(66'h6);     lit("t3b", 4'b1000, 2'd3);
    send(66'h1234);  lit("t3multi", 4'b1100, 2'd2);

    // Write on the same edge as the word: old entry used, next word sees new.
    go();
    wr_addr = 2'd1; wr_pat = 66'h3_0000_0000_0000_00F0; wr_care = {66{1'b1}}; wr_ena = 1'b1; wr_en = 1'b1;
    din = 66'h3_0000_0000_0000_00F0; din_valid = 1'b1;
    go();
    wr_en = 1'b0;
    go();
    din_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    lit("t4old", 4'b1000, 2'd3);
    @(negedge clk);
    lit("t4new", 4'b1010, 2'd1);

    // Disabled entry never hits even with care=0.
    write(2'd3, 66'h0, 66'h0, 1'b0);
    send(66'h6);     lit("t4dis", 4'b0000, 2'd0);

    // Reset in the middle of a stream of hitting words.
    go();
    din = 66'h1234; din_valid = 1'b1;
    repeat (5) go();
    arst_n = 1'b0;
    go();
    arst_n = 1'b1;
    post_valid = 0; post_any = 0; count_en = 1;
    repeat (4) go();
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
    count_en = 0;
    chk("t5.post_valid", 66'(post_valid), 66'd4);
    chk("t5.post_any",   66'(post_any),   66'd0);

`ifdef EQ_MASK_HIT_CNT_EN
    // Saturating counter then clear colliding with a hit.
    write(2'd0, 66'h0, 66'h0, 1'b1);
    go();
    din = 66'h77; din_valid = 1'b1;
    repeat (20) go();
    @(negedge clk);
    chk("t6.sat", 66'(hit_cnt), 66'd15);
    go();
    hit_cnt_clr = 1'b1;
    go();
    hit_cnt_clr = 1'b0;
    @(negedge clk);
    chk("t6.clr", 66'(hit_cnt), 66'd0);
    go();
    din_valid = 1'b0;
    repeat (4) @(negedge clk);
`endif

    // Narrow instance: WIDTH=13 (padded top chunk), NUM_PAT=1.
    s_send("s1", 13'h0AAA, 1'b0);
    s_write(1'b0, 13'h1ABC, 13'h1FFF, 1'b1);
    s_send("s2hit", 13'h1ABC, 1'b1);
    s_send("s2top", 13'h0ABC, 1'b0);
    s_write(1'b1, 13'h0000, 13'h0000, 1'b1);
    s_send("s4keep", 13'h1ABC, 1'b1);
    s_send("s4ign",  13'h0001, 1'b0);
    s_write(1'b0, 13'h0001, 13'h0003, 1'b1);
    s_send("s3hit",  13'h1FF5, 1'b1);
    s_send("s3miss", 13'h0002, 1'b0);
    s_write(1'b0, 13'h0000, 13'h0000, 1'b1);
    s_send("s3all",  13'h1357, 1'b1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
